// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM encoding, queue entry layout
// and the default reset fetch address.
package fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_DISCARD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc_plus4;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Power-of-two FIFO holding fetched instructions; flush empties it and takes
// priority over a same-cycle push or pop.
module fetch_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic [$clog2(DEPTH):0]       count,
   output logic                         empty,
   output logic                         full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign empty   = (count == '0);
   assign full    = (count == DEPTH_C);
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory read at a time, results queued for
// IF/ID; redirects flush the queue and drop any in-flight response.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = FETCH_RESET_PC
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_out,
   output logic [XLEN-1:0] pc_plus4_out
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_state_e    state;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] fetch_pc_inc;

   logic            q_push;
   logic            q_pop;
   logic            q_empty;
   logic            q_full;
   logic [CW-1:0]   q_count;
   logic [CW-1:0]   count_after_pop;
   logic [CW-1:0]   count_after_push;
   fetch_entry_t    q_din;
   fetch_entry_t    q_dout;

   always_comb begin
      q_pop            = ~q_empty & inst_ready;
      q_push           = (state == ST_WAIT) & mem_ack & ~redirect & ~q_full;
      count_after_pop  = q_count - CW'(q_pop);
      count_after_push = count_after_pop + CW'(q_push);
      fetch_pc_inc     = fetch_pc + XLEN'(4);
      q_din.inst       = mem_rdata;
      q_din.pc_plus4   = req_addr + XLEN'(4);
   end

   fetch_queue #(
      .DEPTH (DEPTH),
      .WIDTH (2 * XLEN)
   ) u_queue (
      .clk   (clk),
      .reset (reset),
      .push  (q_push),
      .pop   (q_pop),
      .flush (redirect),
      .din   (q_din),
      .dout  (q_dout),
      .count (q_count),
      .empty (q_empty),
      .full  (q_full)
   );

   // req_addr only moves on entry to WAIT, so mem_addr is stable while a request is live.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         case (state)
            ST_IDLE: begin
               if (redirect) begin
                  state    <= ST_WAIT;
                  fetch_pc <= redirect_pc;
                  req_addr <= redirect_pc;
               end else if (count_after_pop < DEPTH_C) begin
                  state    <= ST_WAIT;
                  req_addr <= fetch_pc;
               end
            end
            ST_WAIT: begin
               if (redirect) begin
                  fetch_pc <= redirect_pc;
                  if (mem_ack) req_addr <= redirect_pc;
                  else         state    <= ST_DISCARD;
               end else if (mem_ack) begin
                  fetch_pc <= fetch_pc_inc;
                  if (count_after_push < DEPTH_C) req_addr <= fetch_pc_inc;
                  else                            state    <= ST_IDLE;
               end
            end
            ST_DISCARD: begin
               if (redirect) fetch_pc <= redirect_pc;
               if (mem_ack) begin
                  state    <= ST_WAIT;
                  req_addr <= redirect ? redirect_pc : fetch_pc;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign mem_req      = (state != ST_IDLE);
   assign mem_addr     = req_addr;
   assign inst_valid   = ~q_empty;
   assign inst_out     = inst_valid ? q_dout.inst     : '0;
   assign pc_plus4_out = inst_valid ? q_dout.pc_plus4 : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, queue-full stall, redirects,
// address wrap and reset during an outstanding request.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        mem_ack;
   logic        inst_ready;

   logic        mem_req,  m2_req;
   logic [31:0] mem_addr, m2_addr;
   logic [31:0] mem_rdata, m2_rdata;
   logic        inst_valid, v2;
   logic [31:0] inst_out, i2;
   logic [31:0] pc_plus4_out, p2;

   int checks;
   int errors;

   // Memory model: returned instruction word equals its address.
   assign mem_rdata = mem_addr;
   assign m2_rdata  = m2_addr;

   fetch_unit dut (
      .clk          (clk),
      .reset        (reset),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .inst_valid   (inst_valid),
      .inst_ready   (inst_ready),
      .inst_out     (inst_out),
      .pc_plus4_out (pc_plus4_out)
   );

   fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk          (clk),
      .reset        (reset),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .mem_req      (m2_req),
      .mem_addr     (m2_addr),
      .mem_ack      (mem_ack),
      .mem_rdata    (m2_rdata),
      .inst_valid   (v2),
      .inst_ready   (inst_ready),
      .inst_out     (i2),
      .pc_plus4_out (p2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1; redirect = 1'b0; redirect_pc = '0; mem_ack = 1'b0; inst_ready = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; redirect = 1'b0; redirect_pc = '0; mem_ack = 1'b1; inst_ready = 1'b0;
      step(); step();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
      checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", inst_out); end
      checks++; if (pc_plus4_out !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want 0", pc_plus4_out); end
      checks++; if (m2_req !== 1'b0) begin errors++; $display("FAIL reset_req2: got %b want 0", m2_req); end
   endtask

   task automatic test_stream();
      pulse_reset();
      mem_ack = 1'b1; inst_ready = 1'b1;
      step();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL stream_first_req: got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %b want 0", inst_valid); end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (inst_valid !== 1'b1 || inst_out !== 32'(4 * i) || pc_plus4_out !== 32'(4 * i + 4)) begin
            errors++; $display("FAIL stream_%0d: got v=%b inst=%h pc4=%h want v=1 inst=%h pc4=%h", i, inst_valid, inst_out, pc_plus4_out, 32'(4 * i), 32'(4 * i + 4));
         end
         checks++; if (mem_addr !== 32'(4 * i + 4)) begin errors++; $display("FAIL stream_addr_%0d: got %h want %h", i, mem_addr, 32'(4 * i + 4)); end
      end
   endtask

   task automatic test_full();
      pulse_reset();
      mem_ack = 1'b1; inst_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++; if (mem_req !== 1'b1 || mem_addr !== 32'(4 * k)) begin errors++; $display("FAIL full_req_%0d: got req=%b addr=%h want req=1 addr=%h", k, mem_req, mem_addr, 32'(4 * k)); end
      end
      for (int k = 0; k < 2; k++) begin
         step();
         checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_idle_%0d: got req=%b want 0", k, mem_req); end
         checks++; if (inst_valid !== 1'b1 || inst_out !== 32'h0) begin errors++; $display("FAIL full_head_%0d: got v=%b inst=%h want v=1 inst=0", k, inst_valid, inst_out); end
      end
      inst_ready = 1'b1;
      step();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("FAIL full_resume: got req=%b addr=%h want req=1 addr=10", mem_req, mem_addr); end
      checks++; if (inst_out !== 32'h4 || pc_plus4_out !== 32'h8) begin errors++; $display("FAIL full_pop_1: got inst=%h pc4=%h want 4/8", inst_out, pc_plus4_out); end
      for (int k = 2; k < 5; k++) begin
         step();
         checks++; if (inst_out !== 32'(4 * k) || pc_plus4_out !== 32'(4 * k + 4)) begin errors++; $display("FAIL full_pop_%0d: got inst=%h pc4=%h want %h/%h", k, inst_out, pc_plus4_out, 32'(4 * k), 32'(4 * k + 4)); end
      end
   endtask

   task automatic test_redirect_wait();
      pulse_reset();
      mem_ack = 1'b0; inst_ready = 1'b1;
      step();
      step();
      redirect = 1'b1; redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL rdw_hold: got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdw_valid: got %b want 0", inst_valid); end
      mem_ack = 1'b1;
      step();
      checks++; if (mem_addr !== 32'h100 || inst_valid !== 1'b0) begin errors++; $display("FAIL rdw_drop: got addr=%h v=%b want addr=100 v=0", mem_addr, inst_valid); end
      step();
      mem_ack = 1'b0;
      checks++; if (inst_valid !== 1'b1 || inst_out !== 32'h100 || pc_plus4_out !== 32'h104) begin errors++; $display("FAIL rdw_first: got v=%b inst=%h pc4=%h want 1/100/104", inst_valid, inst_out, pc_plus4_out); end
   endtask

   task automatic test_redirect_ack();
      pulse_reset();
      mem_ack = 1'b1; inst_ready = 1'b0;
      step(); step(); step();
      checks++; if (inst_valid !== 1'b1 || inst_out !== 32'h0 || mem_addr !== 32'h8) begin errors++; $display("FAIL rda_pre: got v=%b inst=%h addr=%h want 1/0/8", inst_valid, inst_out, mem_addr); end
      redirect = 1'b1; redirect_pc = 32'h200;
      step();
      redirect = 1'b0;
      checks++; if (inst_valid !== 1'b0 || inst_out !== 32'h0 || pc_plus4_out !== 32'h0) begin errors++; $display("FAIL rda_flush: got v=%b inst=%h pc4=%h want 0/0/0", inst_valid, inst_out, pc_plus4_out); end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL rda_addr: got req=%b addr=%h want 1/200", mem_req, mem_addr); end
      step();
      checks++; if (inst_valid !== 1'b1 || inst_out !== 32'h200 || pc_plus4_out !== 32'h204) begin errors++; $display("FAIL rda_next: got v=%b inst=%h pc4=%h want 1/200/204", inst_valid, inst_out, pc_plus4_out); end
   endtask

   task automatic test_wrap();
      pulse_reset();
      mem_ack = 1'b1; inst_ready = 1'b1;
      step();
      checks++; if (m2_req !== 1'b1 || m2_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: got req=%b addr=%h want 1/fffffffc", m2_req, m2_addr); end
      step();
      checks++; if (m2_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", m2_addr); end
      checks++; if (v2 !== 1'b1 || i2 !== 32'hFFFF_FFFC || p2 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got v=%b inst=%h pc4=%h want 1/fffffffc/0", v2, i2, p2); end
   endtask

   task automatic test_reset_mid();
      pulse_reset();
      mem_ack = 1'b1; inst_ready = 1'b0;
      step(); step();
      checks++; if (inst_valid !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL rmid_pre: got v=%b req=%b want 1/1", inst_valid, mem_req); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if (mem_req !== 1'b0 || inst_valid !== 1'b0 || inst_out !== 32'h0) begin errors++; $display("FAIL rmid_reset: got req=%b v=%b inst=%h want 0/0/0", mem_req, inst_valid, inst_out); end
      step();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rmid_restart: got req=%b addr=%h v=%b want 1/0/0", mem_req, mem_addr, inst_valid); end
      checks++; if (m2_req !== 1'b1 || m2_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rmid_restart2: got req=%b addr=%h want 1/fffffffc", m2_req, m2_addr); end
      mem_ack = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_stream();
      test_full();
      test_redirect_wait();
      test_redirect_ack();
      test_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
      $finish;
   end

endmodule
